// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 register configuration sequencer.
package ov7670_pkg;

    // ROM word layout: {reg_addr, reg_value}
    localparam int ROM_ADDR_W = 8;
    localparam int ROM_WORD_W = 16;
    localparam int ROM_REG_W  = 8;
    localparam int ROM_VAL_W  = 8;
    localparam int COUNT_W    = 8;

    // Reserved ROM words that are not register writes
    localparam logic [ROM_WORD_W-1:0] ROM_END_MARKER   = 16'hFFFF;
    localparam logic [ROM_WORD_W-1:0] ROM_DELAY_MARKER = 16'hFFF0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_WRITE,
        ST_DELAY,
        ST_DONE
    } seq_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/ov7670_config_sequencer_if.sv
// ROM read port and SCCB write handshake as seen by the configuration sequencer.
interface ov7670_config_sequencer_if;
    import ov7670_pkg::*;

    logic [ROM_ADDR_W-1:0] rom_addr_o;
    logic [ROM_WORD_W-1:0] rom_data_i;
    logic                  sccb_valid_o;
    logic                  sccb_ready_i;
    logic [ROM_REG_W-1:0]  sccb_reg_o;
    logic [ROM_VAL_W-1:0]  sccb_data_o;

    // Sequencer side
    modport master (
        output rom_addr_o,
        input  rom_data_i,
        output sccb_valid_o,
        input  sccb_ready_i,
        output sccb_reg_o,
        output sccb_data_o
    );

    // ROM / SCCB-master side
    modport slave (
        input  rom_addr_o,
        output rom_data_i,
        input  sccb_valid_o,
        output sccb_ready_i,
        input  sccb_reg_o,
        input  sccb_data_o
    );

endinterface

// File: rtl/ov7670_config_sequencer_delay_timer.sv
// Loadable down-counter with a zero flag, used for the post-write settle delays.
module delay_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Load has priority over decrement; the count never goes below zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ov7670_config_sequencer.sv
// Walks a configuration ROM and issues one SCCB register write per entry,
// honouring delay and end markers, until the end marker or the last address.
module ov7670_config_sequencer
    import ov7670_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES = 250_000,
    parameter int unsigned ROM_DEPTH    = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    ov7670_config_sequencer_if.master bus,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [COUNT_W-1:0]        write_count_o
);

    localparam int unsigned TMR_W = $clog2(DELAY_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DELAY_CYCLES - 1);
    localparam logic [ROM_ADDR_W-1:0] LAST_ADDR = ROM_ADDR_W'(ROM_DEPTH - 1);

    seq_state_e             state_q, state_d;
    logic [ROM_ADDR_W-1:0]  addr_q,  addr_d;
    logic [ROM_REG_W-1:0]   reg_q,   reg_d;
    logic [ROM_VAL_W-1:0]   val_q,   val_d;
    logic [COUNT_W-1:0]     count_q, count_d;

    logic tmr_load;
    logic tmr_dec;
    logic tmr_zero;
    logic at_last;

    assign at_last = (addr_q == LAST_ADDR);

    // Next-state logic: one entry is fetched, decoded, then written or waited on
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        reg_d    = reg_q;
        val_d    = val_q;
        count_d  = count_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                    addr_d  = '0;
                    count_d = '0;
                end
            end
            ST_FETCH: begin
                // ROM is registered: data for addr_q appears one cycle later
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (bus.rom_data_i == ROM_END_MARKER) begin
                    state_d = ST_DONE;
                end else if (bus.rom_data_i == ROM_DELAY_MARKER) begin
                    state_d  = ST_DELAY;
                    tmr_load = 1'b1;
                end else begin
                    state_d = ST_WRITE;
                    reg_d   = bus.rom_data_i[ROM_WORD_W-1 -: ROM_REG_W];
                    val_d   = bus.rom_data_i[ROM_VAL_W-1:0];
                end
            end
            ST_WRITE: begin
                if (bus.sccb_ready_i) begin
                    count_d = sat_inc(count_q);
                    if (at_last) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + ROM_ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DELAY: begin
                if (tmr_zero) begin
                    if (at_last) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + ROM_ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            reg_q   <= '0;
            val_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            reg_q   <= reg_d;
            val_q   <= val_d;
            count_q <= count_d;
        end
    end

    delay_timer #(
        .WIDTH (TMR_W)
    ) u_delay_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .load_val_i (TMR_LOAD),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    assign bus.rom_addr_o   = addr_q;
    assign bus.sccb_valid_o = (state_q == ST_WRITE);
    assign bus.sccb_reg_o   = reg_q;
    assign bus.sccb_data_o  = val_q;
    assign busy_o           = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_o           = (state_q == ST_DONE);
    assign write_count_o    = count_q;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Bench for ov7670_config_sequencer: directed scenarios plus randomized ROM
// images, checked every cycle against a transaction-level model of the ROM walk.
module tb_ov7670_config_sequencer;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] wcount;

    ov7670_config_sequencer_if bus();

    ov7670_config_sequencer #(
        .DELAY_CYCLES (D),
        .ROM_DEPTH    (256)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .bus           (bus.master),
        .busy_o        (busy),
        .done_o        (done),
        .write_count_o (wcount)
    );

    always #5 clk = ~clk;

    // Behavioural ROM with one-cycle registered read
    logic [15:0] rom_mem [256];
    always @(posedge clk) bus.rom_data_i <= rom_mem[bus.rom_addr_o];

    int total = 0;
    int bad   = 0;

    // Transaction-level model: list of expected writes with the number of
    // idle-but-busy cycles that precede each one
    typedef struct {
        logic [7:0] r;
        logic [7:0] d;
        logic [7:0] a;
        int         g;
    } wr_t;
    typedef enum int {M_IDLE, M_RUN, M_DONE} mphase_e;

    wr_t        q[$];
    mphase_e    phase = M_IDLE;
    int         gap = 0;
    int         final_gap = 0;
    logic [7:0] final_addr = 8'd0;
    logic [7:0] m_count = 8'd0;
    logic [7:0] m_reg = 8'd0;
    logic [7:0] m_data = 8'd0;
    logic [7:0] m_addr = 8'd0;
    bit         in_write = 1'b0;
    int         ready_mode = 0;
    int         obs_hs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Walk the ROM image the way the sequence is defined to
    function automatic void build_model();
        int g;
        q.delete();
        g = 0;
        for (int a = 0; a < 256; a++) begin
            if (rom_mem[a] == 16'hFFFF) begin
                final_gap  = g + 2;
                final_addr = 8'(a);
                return;
            end else if (rom_mem[a] == 16'hFFF0) begin
                g = g + 2 + D;
            end else begin
                q.push_back('{r: rom_mem[a][15:8], d: rom_mem[a][7:0], a: 8'(a), g: g + 2});
                g = 0;
            end
        end
        final_gap  = g;
        final_addr = 8'd255;
    endfunction

    function automatic void model_edge();
        if (!rst_n) begin
            phase    = M_IDLE;
            m_count  = 8'd0;
            m_reg    = 8'd0;
            m_data   = 8'd0;
            m_addr   = 8'd0;
            in_write = 1'b0;
            q.delete();
        end else if (phase != M_RUN) begin
            if (start) begin
                build_model();
                phase    = M_RUN;
                gap      = 0;
                m_count  = 8'd0;
                in_write = 1'b0;
            end
        end else if (in_write && bus.sccb_ready_i) begin
            void'(q.pop_front());
            m_count  = (m_count < 8'd255) ? m_count + 8'd1 : 8'd255;
            gap      = 0;
            in_write = 1'b0;
        end
    endfunction

    task automatic model_cmp();
        logic ev, eb, ed;
        ev = 1'b0;
        eb = 1'b0;
        ed = 1'b0;
        if (phase == M_RUN) begin
            eb = 1'b1;
            if (q.size() > 0) begin
                if (gap < q[0].g) begin
                    gap++;
                end else begin
                    ev       = 1'b1;
                    in_write = 1'b1;
                    m_reg    = q[0].r;
                    m_data   = q[0].d;
                    m_addr   = q[0].a;
                end
            end else if (gap < final_gap) begin
                gap++;
            end else begin
                phase  = M_DONE;
                eb     = 1'b0;
                m_addr = final_addr;
            end
        end
        if (phase == M_DONE) ed = 1'b1;
        chk("valid", bus.sccb_valid_o, ev);
        chk("busy", busy, eb);
        chk("done", done, ed);
        chk("reg", bus.sccb_reg_o, m_reg);
        chk("data", bus.sccb_data_o, m_data);
        chk("write_count", wcount, m_count);
        if (ev || phase != M_RUN) chk("rom_addr", bus.rom_addr_o, m_addr);
    endtask

    // One clock: model advances at the edge, outputs compared mid-cycle
    task automatic tick();
        @(posedge clk);
        if (rst_n && bus.sccb_valid_o && bus.sccb_ready_i) obs_hs++;
        model_edge();
        @(negedge clk);
        model_cmp();
        if (ready_mode == 1) bus.sccb_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fill_rom(input logic [15:0] w);
        for (int a = 0; a < 256; a++) rom_mem[a] = w;
    endtask

    // Latency in samples, counting the first sample after the start edge as 1
    task automatic start_and_measure(output int n);
        pulse_start();
        n = 1;
        while (!bus.sccb_valid_o && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done(input int lim);
        int k;
        k = 0;
        while (!done && k < lim) begin
            tick();
            k++;
        end
        chk("done_reached", done, 1'b1);
    endtask

    initial begin
        int n;
        int vcnt;
        int len;
        logic [15:0] w;

        bus.sccb_ready_i = 1'b1;
        fill_rom(16'h0000);

        // Reset state
        repeat (3) tick();
        chk("rst_valid", bus.sccb_valid_o, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_count", wcount, 8'd0);
        chk("rst_addr", bus.rom_addr_o, 8'd0);
        chk("rst_reg", bus.sccb_reg_o, 8'd0);
        chk("rst_data", bus.sccb_data_o, 8'd0);
        rst_n = 1'b1;
        tick();

        // Single write then end marker
        fill_rom(16'hFFFF);
        rom_mem[0] = 16'h1280;
        start_and_measure(n);
        chk("t1_latency", n, 3);
        chk("t1_reg", bus.sccb_reg_o, 8'h12);
        chk("t1_data", bus.sccb_data_o, 8'h80);
        wait_done(100);
        chk("t1_count", wcount, 8'd1);

        // Leading delay marker
        fill_rom(16'hFFFF);
        rom_mem[0] = 16'hFFF0;
        rom_mem[1] = 16'h1180;
        start_and_measure(n);
        chk("t2_latency", n, 2 + D + 2 + 1);
        chk("t2_reg", bus.sccb_reg_o, 8'h11);
        chk("t2_data", bus.sccb_data_o, 8'h80);
        wait_done(100);
        chk("t2_count", wcount, 8'd1);

        // Back-pressure: ready low for 5 cycles during the write
        fill_rom(16'hFFFF);
        rom_mem[0] = 16'h0C00;
        bus.sccb_ready_i = 1'b0;
        start_and_measure(n);
        vcnt = bus.sccb_valid_o ? 1 : 0;
        repeat (5) begin
            tick();
            if (bus.sccb_valid_o) vcnt++;
            chk("t3_hold_reg", bus.sccb_reg_o, 8'h0C);
            chk("t3_hold_data", bus.sccb_data_o, 8'h00);
        end
        bus.sccb_ready_i = 1'b1;
        tick();
        chk("t3_valid_cycles", vcnt, 6);
        chk("t3_count_after", wcount, 8'd1);
        wait_done(100);
        chk("t3_count", wcount, 8'd1);

        // Start ignored during DELAY, honoured in DONE
        fill_rom(16'hFFFF);
        rom_mem[0] = 16'hFFF0;
        rom_mem[1] = 16'h2233;
        pulse_start();
        repeat (3) tick();
        pulse_start();
        chk("t4_busy_after_ignored", busy, 1'b1);
        wait_done(100);
        chk("t4_count", wcount, 8'd1);
        start_and_measure(n);
        chk("t4_restart_latency", n, 2 + D + 2 + 1);
        chk("t4_restart_addr", bus.rom_addr_o, 8'd1);
        wait_done(100);

        // Asynchronous reset while a write is pending
        fill_rom(16'hFFFF);
        rom_mem[0] = 16'h0A01;
        rom_mem[1] = 16'h0C55;
        pulse_start();
        n = 0;
        while (wcount != 8'd1 && n < 100) begin
            tick();
            n++;
        end
        bus.sccb_ready_i = 1'b0;
        n = 0;
        while (!bus.sccb_valid_o && n < 100) begin
            tick();
            n++;
        end
        chk("t5_pre_valid", bus.sccb_valid_o, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", bus.sccb_valid_o, 1'b0);
        chk("t5_rst_reg", bus.sccb_reg_o, 8'd0);
        chk("t5_rst_data", bus.sccb_data_o, 8'd0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_done", done, 1'b0);
        chk("t5_rst_count", wcount, 8'd0);
        chk("t5_rst_addr", bus.rom_addr_o, 8'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        bus.sccb_ready_i = 1'b1;
        start_and_measure(n);
        chk("t5_restart_latency", n, 3);
        chk("t5_restart_addr", bus.rom_addr_o, 8'd0);
        chk("t5_restart_reg", bus.sccb_reg_o, 8'h0A);
        wait_done(100);
        chk("t5_count", wcount, 8'd2);

        // No end marker: every entry written, count saturates, no wrap
        fill_rom(16'h0000);
        obs_hs = 0;
        pulse_start();
        wait_done(2000);
        chk("t6_handshakes", obs_hs, 256);
        chk("t6_count", wcount, 8'd255);
        chk("t6_addr", bus.rom_addr_o, 8'd255);

        // Randomized ROM images with random ready
        for (int it = 0; it < 8; it++) begin
            for (int a = 0; a < 256; a++) rom_mem[a] = 16'($urandom);
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    rom_mem[i] = 16'hFFF0;
                end else begin
                    w = 16'($urandom);
                    if (w >= 16'hFFF0) w = w & 16'h7FFF;
                    rom_mem[i] = w;
                end
            end
            rom_mem[len] = 16'hFFFF;
            ready_mode = 1;
            pulse_start();
            wait_done(3000);
            ready_mode = 0;
            bus.sccb_ready_i = 1'b1;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ov7670_config_sequencer.md
OV7670_CONFIG_SEQUENCER -- requirements
Module: ov7670_config_sequencer

Interface
REQ-001 Parameter DELAY_CYCLES, default 250_000, clk_i cycles waited per delay marker (10 ms at 25 MHz); legal range 1..2^24-1.
REQ-002 Parameter ROM_DEPTH, default 256, number of addressable ROM entries.
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  single-cycle request to run the configuration sequence from entry 0.
REQ-006 rom_addr_o  output  8  address to the configuration ROM.
REQ-007 rom_data_i  input  16  ROM word {reg_addr[15:8], reg_value[7:0]}, valid 1 cycle after rom_addr_o is sampled (registered read).
REQ-008 sccb_valid_o  output  1  register write request to the SCCB master.
REQ-009 sccb_ready_i  input  1  SCCB master can accept a write.
REQ-010 sccb_reg_o  output  8  register address of the pending write.
REQ-011 sccb_data_o  output  8  register value of the pending write.
REQ-012 busy_o  output  1  high in every state except IDLE and DONE.
REQ-013 done_o  output  1  high while in DONE.
REQ-014 write_count_o  output  8  number of completed SCCB handshakes since the last accepted start.

Function
REQ-015 States: IDLE, FETCH, DECODE, WRITE, DELAY, DONE.
REQ-016 IDLE or DONE, start_i=1 -> FETCH; rom_addr_o<=0, write_count_o<=0, done_o cleared.
REQ-017 start_i in FETCH/DECODE/WRITE/DELAY is ignored; there is no abort.
REQ-018 FETCH lasts exactly 1 cycle (ROM read latency), then DECODE.
REQ-019 DECODE samples rom_data_i: 16'hFFFF -> DONE; 16'hFFF0 -> DELAY with counter loaded DELAY_CYCLES-1; any other value -> WRITE with sccb_reg_o<=rom_data_i[15:8], sccb_data_o<=rom_data_i[7:0].
REQ-020 sccb_valid_o is high exactly in WRITE, asserted 3 cycles after the edge that sampled start_i (first entry is a register write).
REQ-021 In WRITE, sccb_valid_o, sccb_reg_o and sccb_data_o stay stable until a rising edge with sccb_valid_o && sccb_ready_i; sccb_ready_i toggling before then has no effect.
REQ-022 On handshake: write_count_o increments (saturating at 255), rom_addr_o increments, next state FETCH.
REQ-023 DELAY decrements the counter every cycle; at 0, rom_addr_o increments and the next state is FETCH; total cycles in DELAY = DELAY_CYCLES.
REQ-024 Address wrap: an increment from rom_addr_o=ROM_DEPTH-1 goes to DONE instead of FETCH; rom_addr_o does not wrap.
REQ-025 A delay marker at entry 0 and consecutive delay markers are legal and produce back-to-back delays.
REQ-026 DONE holds done_o=1 and all other outputs stable until the next start_i.
REQ-027 Outside WRITE, sccb_reg_o/sccb_data_o hold their last value; sccb_valid_o=0.

Reset
REQ-028 rst_ni low asynchronously forces IDLE, rom_addr_o=0, sccb_valid_o=0, sccb_reg_o=0, sccb_data_o=0, busy_o=0, done_o=0, write_count_o=0, delay counter 0.
REQ-029 Reset asserted mid-sequence (including during WRITE with the handshake pending) abandons the sequence; the next start after release restarts from entry 0.

Structure
REQ-030 Package ov7670_pkg holds the state enum, ROM_END_MARKER=16'hFFFF, ROM_DELAY_MARKER=16'hFFF0 and the ROM word field widths.
REQ-031 The delay counter is one sub-module, delay_timer (load, count-down, zero flag), with width $clog2(DELAY_CYCLES+1).
REQ-032 The ROM is instantiated outside this block and connects only through rom_addr_o/rom_data_i.

Verification (bench: DELAY_CYCLES=8, behavioural 1-cycle ROM model)
REQ-033 ROM {0:12_80, 1:FFFF}, sccb_ready_i=1, start -> one handshake reg=0x12 data=0x80; valid 3 cycles after start; done_o=1, write_count_o=1.
REQ-034 ROM {0:FFF0, 1:11_80, 2:FFFF} -> exactly 8 cycles in DELAY, then write reg=0x11 data=0x80, done, write_count_o=1.
REQ-035 sccb_ready_i low for 5 cycles during WRITE of 0C_00 -> valid held 6 cycles, reg/data stable, write_count_o increments once.
REQ-036 start_i pulsed during DELAY and again in DONE -> first ignored; second restarts at address 0 with write_count_o cleared.
REQ-037 rst_ni low mid-WRITE -> all outputs 0 immediately (before the next edge); next start begins at entry 0.
REQ-038 ROM with no end marker (all 256 entries 00_00) -> 256 handshakes, write_count_o=255 (saturated), DONE without address wrap.
